// File: rtl/morph_pkg.sv
// Shared constants, state encoding and the lane compare helper for the
// 3x3 morphology engine.
package morph_pkg;

   localparam logic MODE_DILATE = 1'b0;
   localparam logic MODE_ERODE  = 1'b1;
   localparam logic SE_CROSS    = 1'b0;
   localparam logic SE_SQUARE   = 1'b1;

   // Widest lane the helper below can handle; lanes are zero-extended into it.
   localparam int LANE_MAX_W = 32;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } morph_state_e;

   // Unsigned max (dilate) or min (erode) of two lane values.
   function automatic logic [LANE_MAX_W-1:0] laneReduce(
      input logic                  erode,
      input logic [LANE_MAX_W-1:0] a,
      input logic [LANE_MAX_W-1:0] b
   );
      if (erode == MODE_ERODE) begin
         return (a < b) ? a : b;
      end
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/morph_lane_reduce.sv
// One DATA_W lane of the morphology reduction: row partials are registered
// one cycle after the window shift, the final value is formed from them.
module morph_lane_reduce
   import morph_pkg::*;
#(
   parameter int DATA_W = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] win_i [9],
   input  logic              mode_i,
   input  logic              se_i,
   input  logic              edge_i,
   output logic [DATA_W-1:0] result_o
);

   // win_i index is column*3 + row; column 0 is the newest (right) column,
   // column 1 the centre and column 2 the oldest (left) column.
   logic [DATA_W-1:0] leftCol [3];
   logic [DATA_W-1:0] rowAll  [3];
   logic [DATA_W-1:0] part_d  [3];
   logic [DATA_W-1:0] part_q  [3];
   logic              mode_q;

   function automatic logic [DATA_W-1:0] pick(
      input logic              erode,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      return DATA_W'(laneReduce(erode, LANE_MAX_W'(a), LANE_MAX_W'(b)));
   endfunction

   // Per-row partials; the left column mirrors the centre at the line start,
   // and the cross only keeps the side neighbours of the middle row.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         leftCol[r] = edge_i ? win_i[3+r] : win_i[6+r];
         rowAll[r]  = pick(mode_i, pick(mode_i, win_i[r], win_i[3+r]), leftCol[r]);
         part_d[r]  = rowAll[r];
      end
      if (se_i == SE_CROSS) begin
         part_d[0] = win_i[3];
         part_d[2] = win_i[5];
      end
   end

   // Register the row partials together with the mode they were built with,
   // so a new line latching a different mode cannot disturb the last stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 3; r++) begin
            part_q[r] <= '0;
         end
         mode_q <= MODE_DILATE;
      end else begin
         for (int r = 0; r < 3; r++) begin
            part_q[r] <= part_d[r];
         end
         mode_q <= mode_i;
      end
   end

   assign result_o = pick(mode_q, pick(mode_q, part_q[0], part_q[1]), part_q[2]);

endmodule

// File: rtl/matrix_morph.sv
// 3x3 dilate/erode engine with cross or square element, per-channel lanes,
// edge replication and a one-cycle end-of-line flush.
module matrix_morph
   import morph_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int CH        = 3,
   parameter int PIC_WIDTH = 250
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_in,
   output logic                 ready,
   input  logic                 sol,
   input  logic                 mode,
   input  logic                 se_sel,
   input  logic [DATA_W*CH-1:0] din1,
   input  logic [DATA_W*CH-1:0] din2,
   input  logic [DATA_W*CH-1:0] din3,
   output logic                 valid_out,
   output logic [DATA_W*CH-1:0] dout,
   output logic                 line_err
);

   localparam int BW    = DATA_W * CH;
   localparam int COL_W = (PIC_WIDTH > 2) ? $clog2(PIC_WIDTH) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(PIC_WIDTH - 1);

   morph_state_e     state_q;
   logic [COL_W-1:0] col_q;
   logic [COL_W-1:0] col_d;
   logic [COL_W-1:0] beatCol;
   logic             lineMode_q;
   logic             lineSe_q;
   logic             comp_q;
   logic             edge_q;
   logic             stage1_q;
   logic             accept;
   logic [BW-1:0]    win_q [3][3];
   logic [BW-1:0]    laneResult;

   assign ready   = (state_q == ST_RUN);
   assign accept  = valid_in && ready;
   assign beatCol = sol ? '0 : col_q;
   assign col_d   = (beatCol == LAST_COL) ? '0 : beatCol + COL_W'(1);

   // Window, column count, RUN/FLUSH sequencing, line latches and the
   // two-stage valid pipeline that follows every compute.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         col_q      <= '0;
         lineMode_q <= MODE_DILATE;
         lineSe_q   <= SE_CROSS;
         comp_q     <= 1'b0;
         edge_q     <= 1'b0;
         stage1_q   <= 1'b0;
         valid_out  <= 1'b0;
         dout       <= '0;
         line_err   <= 1'b0;
         for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
               win_q[c][r] <= '0;
            end
         end
      end else begin
         comp_q    <= 1'b0;
         edge_q    <= 1'b0;
         line_err  <= 1'b0;
         stage1_q  <= comp_q;
         valid_out <= stage1_q;
         if (stage1_q) begin
            dout <= laneResult;
         end
         case (state_q)
            ST_RUN: begin
               if (accept) begin
                  for (int r = 0; r < 3; r++) begin
                     win_q[2][r] <= win_q[1][r];
                     win_q[1][r] <= win_q[0][r];
                  end
                  win_q[0][0] <= din1;
                  win_q[0][1] <= din2;
                  win_q[0][2] <= din3;
                  col_q    <= col_d;
                  comp_q   <= (beatCol != '0);
                  edge_q   <= (beatCol == COL_W'(1));
                  line_err <= sol && (col_q != '0);
                  if (beatCol == '0) begin
                     lineMode_q <= mode;
                     lineSe_q   <= se_sel;
                  end
                  if (beatCol == LAST_COL) begin
                     state_q <= ST_FLUSH;
                  end
               end
            end
            ST_FLUSH: begin
               for (int r = 0; r < 3; r++) begin
                  win_q[2][r] <= win_q[1][r];
                  win_q[1][r] <= win_q[0][r];
               end
               comp_q  <= 1'b1;
               state_q <= ST_RUN;
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_lane
      logic [DATA_W-1:0] laneWin [9];
      logic [DATA_W-1:0] laneOut;

      for (genvar c = 0; c < 3; c++) begin : g_col
         for (genvar r = 0; r < 3; r++) begin : g_row
            assign laneWin[c*3+r] = win_q[c][r][i*DATA_W +: DATA_W];
         end
      end

      morph_lane_reduce #(
         .DATA_W (DATA_W)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .win_i    (laneWin),
         .mode_i   (lineMode_q),
         .se_i     (lineSe_q),
         .edge_i   (edge_q),
         .result_o (laneOut)
      );

      assign laneResult[i*DATA_W +: DATA_W] = laneOut;
   end

endmodule

// File: tb/tb_matrix_morph.sv
// Randomised bench for matrix_morph with a behavioural model that keeps the
// accepted pixels of the current line and evaluates each output from the
// clamped 3x3 neighbourhood.
module tb_matrix_morph;

   localparam int DATA_W = 8;
   localparam int CH     = 3;
   localparam int W      = 8;
   localparam int BW     = DATA_W * CH;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          validIn;
   logic          ready;
   logic          solIn;
   logic          modeIn;
   logic          seIn;
   logic [BW-1:0] din1;
   logic [BW-1:0] din2;
   logic [BW-1:0] din3;
   logic          validOut;
   logic [BW-1:0] dout;
   logic          lineErr;

   typedef struct {
      logic [BW-1:0] val;
      int            cyc;
      int            col;
   } exp_t;

   exp_t          expQ[$];
   int            cyc = 0;
   int            compared = 0;
   int            mismatched = 0;
   int            totalPushed = 0;
   int            seenOut = 0;
   bit            flushPending = 0;
   bit            lineErrExp = 0;
   bit            accepted = 0;
   bit            modeLine = 0;
   bit            seLine = 0;
   bit            needSol = 0;
   int            mcol = 0;
   logic [BW-1:0] lineBuf [W][3];

   always #5 clk = ~clk;

   // Device under test
   matrix_morph #(
      .DATA_W    (DATA_W),
      .CH        (CH),
      .PIC_WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (validIn),
      .ready     (ready),
      .sol       (solIn),
      .mode      (modeIn),
      .se_sel    (seIn),
      .din1      (din1),
      .din2      (din2),
      .din3      (din3),
      .valid_out (validOut),
      .dout      (dout),
      .line_err  (lineErr)
   );

   // Watchdog so the run can never hang
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   function automatic logic [DATA_W-1:0] laneOf(input logic [BW-1:0] pix, input int l);
      logic [BW-1:0] t;
      t = pix >> (l * DATA_W);
      return t[DATA_W-1:0];
   endfunction

   function automatic logic [BW-1:0] rep(input logic [DATA_W-1:0] v);
      logic [BW-1:0] p;
      for (int l = 0; l < CH; l++) p[l*DATA_W +: DATA_W] = v;
      return p;
   endfunction

   // Reference: reduce the clamped neighbourhood of centre column c
   function automatic logic [BW-1:0] refPixel(input int c);
      logic [BW-1:0] res;
      int cl, cr, best;
      int vals[$];
      cl = (c > 0) ? c - 1 : 0;
      cr = (c < W - 1) ? c + 1 : W - 1;
      for (int l = 0; l < CH; l++) begin
         vals.delete();
         for (int r = 0; r < 3; r++) vals.push_back(int'(laneOf(lineBuf[c][r], l)));
         vals.push_back(int'(laneOf(lineBuf[cl][1], l)));
         vals.push_back(int'(laneOf(lineBuf[cr][1], l)));
         if (seLine) begin
            vals.push_back(int'(laneOf(lineBuf[cl][0], l)));
            vals.push_back(int'(laneOf(lineBuf[cl][2], l)));
            vals.push_back(int'(laneOf(lineBuf[cr][0], l)));
            vals.push_back(int'(laneOf(lineBuf[cr][2], l)));
         end
         best = vals[0];
         foreach (vals[i]) begin
            if (modeLine ? (vals[i] < best) : (vals[i] > best)) best = vals[i];
         end
         res[l*DATA_W +: DATA_W] = DATA_W'(best);
      end
      return res;
   endfunction

   task automatic pushExp(input int c);
      exp_t e;
      e.val = refPixel(c);
      e.cyc = cyc + 2;
      e.col = c;
      expQ.push_back(e);
      totalPushed++;
   endtask

   // Model step for the rising edge just taken
   task automatic modelUpdate();
      int c;
      lineErrExp = 0;
      accepted   = 0;
      if (flushPending) begin
         flushPending = 0;
         pushExp(W - 1);
      end else if (validIn) begin
         accepted = 1;
         c = solIn ? 0 : mcol;
         if (solIn && mcol != 0) lineErrExp = 1;
         lineBuf[c][0] = din1;
         lineBuf[c][1] = din2;
         lineBuf[c][2] = din3;
         if (c == 0) begin
            modeLine = modeIn;
            seLine   = seIn;
         end else begin
            pushExp(c - 1);
         end
         if (c == W - 1) begin
            flushPending = 1;
            mcol = 0;
         end else begin
            mcol = c + 1;
         end
      end
   endtask

   task automatic checkCycle();
      bit expV;
      checkOutput("ready", ready, !flushPending);
      checkOutput("line_err", lineErr, lineErrExp);
      expV = (expQ.size() > 0) && (expQ[0].cyc == cyc);
      checkOutput("valid_out", validOut, expV);
      if (validOut) seenOut++;
      if (expV) begin
         checkOutput($sformatf("dout_col%0d", expQ[0].col), dout, expQ[0].val);
         void'(expQ.pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst_n) modelUpdate();
      else accepted = 0;
      @(negedge clk);
      if (rst_n) checkCycle();
   endtask

   function automatic logic [BW-1:0] pixelFor(input int kind, input int c, input int r, input int seed);
      logic [BW-1:0] p;
      p = '0;
      case (kind)
         1: p = (r == 1 && c == 3) ? rep(8'd200) : rep(8'd10);
         2: p = (r == 0 && c == 5) ? rep(8'd0) : rep(8'd50);
         3: p = (c == 0) ? rep(8'd5) : rep(8'd9);
         4: p = (c == W - 1) ? rep(8'd5) : rep(8'd9);
         5: for (int l = 0; l < CH; l++) p[l*DATA_W +: DATA_W] = DATA_W'($urandom_range(3));
         6: for (int l = 0; l < CH; l++) p[l*DATA_W +: DATA_W] = DATA_W'(c*37 + r*11 + l*90 + seed);
         default: p = BW'($urandom);
      endcase
      return p;
   endfunction

   // One accepted column; held until the model says it was taken
   task automatic applyStimulus(input logic [BW-1:0] p1, input logic [BW-1:0] p2, input logic [BW-1:0] p3,
                                input logic s, input logic md, input logic se);
      int tries = 0;
      validIn = 1'b1;
      din1 = p1; din2 = p2; din3 = p3;
      solIn = s; modeIn = md; seIn = se;
      do begin
         tick();
         tries++;
      end while (!accepted && tries < 4);
      if (!accepted) checkOutput("accept_bound", 64'd0, 64'd1);
      validIn = 1'b0;
   endtask

   task automatic sendLine(input int kind, input bit md, input bit se, input int abortAt,
                           input int gapPct, input bit forceSol);
      int seed, last;
      bit s, bm, bs;
      seed = int'($urandom_range(255));
      last = (abortAt > 0) ? abortAt : W;
      for (int c = 0; c < last; c++) begin
         for (int g = 0; g < 3 && int'($urandom_range(99)) < gapPct; g++) begin
            validIn = 1'b0;
            din1 = BW'($urandom); din2 = BW'($urandom); din3 = BW'($urandom);
            solIn = 1'($urandom); modeIn = 1'($urandom); seIn = 1'($urandom);
            tick();
         end
         s  = (c == 0) ? (forceSol || 1'($urandom)) : 1'b0;
         bm = (c == 0) ? md : 1'($urandom);
         bs = (c == 0) ? se : 1'($urandom);
         applyStimulus(pixelFor(kind, c, 0, seed), pixelFor(kind, c, 1, seed), pixelFor(kind, c, 2, seed), s, bm, bs);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      validIn = 1'b0; solIn = 1'b0; modeIn = 1'b0; seIn = 1'b0;
      din1 = '0; din2 = '0; din3 = '0;
      for (int c = 0; c < W; c++) for (int r = 0; r < 3; r++) lineBuf[c][r] = '0;
      #12;
      checkOutput("reset_ready", ready, 1);
      checkOutput("reset_valid_out", validOut, 0);
      checkOutput("reset_dout", dout, 0);
      checkOutput("reset_line_err", lineErr, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed: dilate square spike, erode cross/square, edges");
      sendLine(1, 1'b0, 1'b1, 0, 0, 1'b1);
      sendLine(2, 1'b1, 1'b0, 0, 10, 1'b1);
      sendLine(2, 1'b1, 1'b1, 0, 10, 1'b0);
      sendLine(3, 1'b1, 1'b1, 0, 0, 1'b1);
      sendLine(4, 1'b1, 1'b1, 0, 0, 1'b0);
      sendLine(0, 1'b0, 1'b1, 0, 0, 1'b0);

      $display("[TB] continuous valid over three lines");
      for (int n = 0; n < 3; n++) sendLine(0, 1'(n), 1'(n >> 1), 0, 0, 1'b1);

      $display("[TB] per-lane independence with gaps");
      for (int n = 0; n < 4; n++) sendLine(6, 1'(n), 1'(n >> 1), 0, 30, 1'b0);

      $display("[TB] premature sol at column 4");
      sendLine(6, 1'b0, 1'b1, 4, 0, 1'b1);
      sendLine(6, 1'b1, 1'b0, 0, 0, 1'b1);

      $display("[TB] random lines");
      needSol = 0;
      for (int n = 0; n < 24; n++) begin
         int ab;
         ab = ($urandom_range(4) == 0) ? int'($urandom_range(W - 1, 1)) : 0;
         sendLine(int'($urandom_range(6)), 1'($urandom), 1'($urandom), ab, int'($urandom_range(40)), needSol);
         needSol = (ab != 0);
      end

      $display("[TB] reset during flush");
      sendLine(0, 1'b0, 1'b1, 0, 0, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("flushrst_ready", ready, 1);
      checkOutput("flushrst_valid_out", validOut, 0);
      checkOutput("flushrst_dout", dout, 0);
      checkOutput("flushrst_line_err", lineErr, 0);
      totalPushed -= expQ.size();
      expQ.delete();
      flushPending = 0; lineErrExp = 0; mcol = 0; modeLine = 0; seLine = 0;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      sendLine(5, 1'b1, 1'b1, 0, 20, 1'b0);
      sendLine(0, 1'b0, 1'b0, 0, 20, 1'b0);

      validIn = 1'b0;
      repeat (6) tick();
      checkOutput("output_count", seenOut, totalPushed);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
